// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue between fetch and decode: a DEPTH-entry FIFO of {pc, instr, adel}
// with a registered-only fetch_ready and a bubble on the decode side whenever it is empty.
module inst_fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flushD,
  input  logic              fetch_valid,
  output logic              fetch_ready,
  input  logic [31:0]       fetch_pc,
  input  logic [31:0]       fetch_instr,
  input  logic              fetch_adel,
  input  logic              stallD,
  output logic              validD,
  output logic [31:0]       instrD,
  output logic [31:0]       pcD,
  output logic              adelD,
  output logic [ADDR_W:0]   countQ
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } entry_t;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  entry_t              mem_q [DEPTH];
  entry_t              mem_d [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                push, pop;

  // Ready comes from registered occupancy only, so stallD never reaches the fetch side.
  assign fetch_ready = ~rst & (count_q != FULL_CNT);
  assign validD      = (count_q != '0);
  assign push        = fetch_valid & fetch_ready & ~flushD;
  assign pop         = validD & ~stallD & ~flushD;
  assign countQ      = count_q;

  assign pcD    = validD ? mem_q[rd_ptr_q].pc    : 32'h0;
  assign instrD = validD ? mem_q[rd_ptr_q].instr : 32'h0;
  assign adelD  = validD ? mem_q[rd_ptr_q].adel  : 1'b0;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flushD) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = '{pc: fetch_pc, instr: fetch_instr, adel: fetch_adel};
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage is deliberately left uncleared; the head mux hides it while empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: directed scenarios plus a randomized run
// compared against a queue-based reference model.
module tb_inst_fetch_queue;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic              clk = 0, rst = 1, flushD = 0, fetch_valid = 0, fetch_adel = 0, stallD = 0;
  logic [31:0]       fetch_pc = 0, fetch_instr = 0;
  logic              fetch_ready, validD, adelD;
  logic [31:0]       instrD, pcD;
  logic [ADDR_W:0]   countQ;
  int                checks = 0, errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } ent_t;
  ent_t mq[$];

  inst_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .flushD(flushD),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_pc(fetch_pc), .fetch_instr(fetch_instr), .fetch_adel(fetch_adel),
    .stallD(stallD), .validD(validD), .instrD(instrD), .pcD(pcD), .adelD(adelD),
    .countQ(countQ)
  );

  always #5 clk = ~clk;

  // Advance one clock, updating the reference queue with the inputs present before the edge.
  task automatic tick();
    ent_t e;
    int sz;
    sz = mq.size();
    e.pc = fetch_pc; e.instr = fetch_instr; e.adel = fetch_adel;
    if (rst || flushD) mq.delete();
    else begin
      if (sz > 0 && !stallD) void'(mq.pop_front());
      if (fetch_valid && sz < DEPTH) mq.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1; fetch_valid = 1; fetch_pc = 32'h1234; #1;
    checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low got=%b exp=0", fetch_ready); end
    tick(); tick();
    rst = 0; fetch_valid = 0; #1;
    checks++; if (countQ !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", countQ); end
    checks++; if (validD !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", validD); end
    checks++; if (instrD !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h exp=0", instrD); end
    checks++; if (pcD !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", pcD); end
    checks++; if (adelD !== 1'b0) begin errors++; $display("FAIL reset_adel got=%b exp=0", adelD); end
    checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", fetch_ready); end
  endtask

  task automatic test_streaming();
    logic [31:0] ins [3];
    stallD = 0;
    for (int i = 0; i < 3; i++) begin
      ins[i] = $urandom;
      fetch_valid = 1; fetch_pc = 32'hBFC0_0000 + 32'(4*i); fetch_instr = ins[i]; fetch_adel = 0;
      tick();
      checks++; if (pcD !== 32'hBFC0_0000 + 32'(4*i)) begin errors++; $display("FAIL stream_pc%0d got=%h exp=%h", i, pcD, 32'hBFC0_0000 + 32'(4*i)); end
      checks++; if (instrD !== ins[i]) begin errors++; $display("FAIL stream_instr%0d got=%h exp=%h", i, instrD, ins[i]); end
      checks++; if (countQ !== 3'd1) begin errors++; $display("FAIL stream_count%0d got=%0d exp=1", i, countQ); end
    end
    fetch_valid = 0;
    tick();
    checks++; if (validD !== 1'b0 || countQ !== 3'd0) begin errors++; $display("FAIL stream_drain valid=%b count=%0d exp 0/0", validD, countQ); end
  endtask

  task automatic test_fill_stall();
    logic [31:0] heads [3];
    stallD = 1;
    for (int i = 0; i < 5; i++) begin
      fetch_valid = 1; fetch_pc = 32'hBFC0_0000 + 32'(4*i); fetch_instr = 32'(i); fetch_adel = 0; #1;
      checks++; if (fetch_ready !== (i < 4)) begin errors++; $display("FAIL fill_ready%0d got=%b exp=%b", i, fetch_ready, (i < 4)); end
      if (i < 4) tick();
    end
    checks++; if (countQ !== 3'd4) begin errors++; $display("FAIL fill_count got=%0d exp=4", countQ); end
    checks++; if (pcD !== 32'hBFC0_0000) begin errors++; $display("FAIL fill_head got=%h exp=bfc00000", pcD); end
    tick();
    checks++; if (pcD !== 32'hBFC0_0000 || countQ !== 3'd4) begin errors++; $display("FAIL stall_hold pc=%h count=%0d exp bfc00000/4", pcD, countQ); end
    stallD = 0;
    tick();
    checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL unstall_ready got=%b exp=1", fetch_ready); end
    checks++; if (countQ !== 3'd3 || pcD !== 32'hBFC0_0004) begin errors++; $display("FAIL unstall_pop1 count=%0d pc=%h exp 3/bfc00004", countQ, pcD); end
    tick();
    fetch_valid = 0;
    checks++; if (countQ !== 3'd3) begin errors++; $display("FAIL unstall_push5 count=%0d exp=3", countQ); end
    heads[0] = 32'hBFC0_0008; heads[1] = 32'hBFC0_000C; heads[2] = 32'hBFC0_0010;
    for (int i = 0; i < 3; i++) begin
      checks++; if (pcD !== heads[i]) begin errors++; $display("FAIL drain_order%0d got=%h exp=%h", i, pcD, heads[i]); end
      tick();
    end
    checks++; if (validD !== 1'b0) begin errors++; $display("FAIL drain_empty got=%b exp=0", validD); end
  endtask

  task automatic test_wrap();
    logic [31:0] got[$];
    int n = 0, cyc = 0;
    while (got.size() < 10 && cyc < 300) begin
      stallD = ($urandom_range(0, 2) == 0);
      fetch_valid = (n < 10) && ($urandom_range(0, 3) != 0);
      fetch_pc = 32'h0040_0000 + 32'(4*n); fetch_instr = ~fetch_pc; fetch_adel = 0; #1;
      checks++; if (countQ > 3'd4) begin errors++; $display("FAIL wrap_count_bound got=%0d exp<=4", countQ); end
      if (validD && !stallD) got.push_back(pcD);
      if (fetch_valid && fetch_ready) n++;
      tick();
      cyc++;
    end
    fetch_valid = 0; stallD = 0;
    checks++; if (got.size() != 10) begin errors++; $display("FAIL wrap_timeout popped=%0d exp=10", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      checks++; if (got[i] !== 32'h0040_0000 + 32'(4*i)) begin errors++; $display("FAIL wrap_order%0d got=%h exp=%h", i, got[i], 32'h0040_0000 + 32'(4*i)); end
    end
    tick();
  endtask

  task automatic test_flush();
    stallD = 1;
    for (int i = 0; i < 3; i++) begin
      fetch_valid = 1; fetch_pc = 32'h0000_1000 + 32'(4*i); fetch_instr = 32'hA0 + 32'(i);
      tick();
    end
    checks++; if (countQ !== 3'd3) begin errors++; $display("FAIL flush_pre_count got=%0d exp=3", countQ); end
    flushD = 1; stallD = 0; fetch_valid = 1; fetch_pc = 32'hDEAD_0000;
    tick();
    flushD = 0;
    checks++; if (countQ !== 3'd0 || validD !== 1'b0) begin errors++; $display("FAIL flush_clear count=%0d valid=%b exp 0/0", countQ, validD); end
    checks++; if (pcD !== 32'h0 || instrD !== 32'h0) begin errors++; $display("FAIL flush_bubble pc=%h instr=%h exp 0/0", pcD, instrD); end
    fetch_pc = 32'h8000_0180; fetch_instr = 32'h4200_0018;
    tick();
    fetch_valid = 0; stallD = 1;
    checks++; if (pcD !== 32'h8000_0180 || countQ !== 3'd1) begin errors++; $display("FAIL flush_redirect pc=%h count=%0d exp 80000180/1", pcD, countQ); end
    stallD = 0;
    tick();
  endtask

  task automatic test_adel();
    logic [31:0] pcs [3];
    logic        ad  [3];
    pcs[0] = 32'h10; pcs[1] = 32'h1; pcs[2] = 32'h20;
    ad[0] = 0; ad[1] = 1; ad[2] = 0;
    stallD = 1;
    for (int i = 0; i < 3; i++) begin
      fetch_valid = 1; fetch_pc = pcs[i]; fetch_adel = ad[i]; fetch_instr = 32'(i);
      tick();
    end
    fetch_valid = 0; fetch_adel = 0; stallD = 0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (adelD !== ad[i] || pcD !== pcs[i]) begin errors++; $display("FAIL adel_head%0d adel=%b pc=%h exp %b/%h", i, adelD, pcD, ad[i], pcs[i]); end
      tick();
    end
    checks++; if (adelD !== 1'b0) begin errors++; $display("FAIL adel_empty got=%b exp=0", adelD); end
  endtask

  task automatic test_random();
    logic [31:0] epc, ein;
    logic        ead;
    for (int c = 0; c < 600; c++) begin
      rst         = ($urandom_range(0, 60) == 0);
      flushD      = ($urandom_range(0, 25) == 0);
      stallD      = ($urandom_range(0, 2) == 0);
      fetch_valid = ($urandom_range(0, 3) != 0);
      fetch_pc = $urandom; fetch_instr = $urandom; fetch_adel = $urandom_range(0, 1);
      #1;
      epc = (mq.size() > 0) ? mq[0].pc    : 32'h0;
      ein = (mq.size() > 0) ? mq[0].instr : 32'h0;
      ead = (mq.size() > 0) ? mq[0].adel  : 1'b0;
      checks++;
      if (countQ !== 3'(mq.size()) || validD !== (mq.size() > 0) ||
          fetch_ready !== (!rst && mq.size() < DEPTH) ||
          pcD !== epc || instrD !== ein || adelD !== ead) begin
        errors++;
        $display("FAIL rand_cyc%0d count=%0d/%0d valid=%b ready=%b/%b pc=%h/%h instr=%h/%h adel=%b/%b",
                 c, countQ, mq.size(), validD, fetch_ready, (!rst && mq.size() < DEPTH),
                 pcD, epc, instrD, ein, adelD, ead);
      end
      tick();
    end
    rst = 0; flushD = 0; fetch_valid = 0; stallD = 0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_fill_stall();
    test_wrap();
    test_flush();
    test_adel();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Instruction fetch queue between instruction fetch and the decode stage. It buffers up to DEPTH fetched instructions, each with its PC and a fetch address-error flag. It presents the oldest entry to decode as instrD/pcD and pops it when decode is not stalled. It is cleared on any redirect (branch, jump, exception, eret), so fetch latency and decode stalls are decoupled without a combinational path from stallD to the fetch side.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥2
- ADDR_W, 2, log2(DEPTH); pointer width

Ports:
- clk  input  1  core clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- flushD  input  1  discard all entries (redirect); highest priority after rst
- fetch_valid  input  1  fetch offers an entry this cycle
- fetch_ready  output  1  queue accepts an entry this cycle
- fetch_pc  input  32  PC of offered instruction
- fetch_instr  input  32  offered instruction word
- fetch_adel  input  1  fetch raised address error for this PC
- stallD  input  1  decode holds its current instruction
- validD  output  1  instrD/pcD hold a real instruction
- instrD  output  32  head instruction, to the main decoder
- pcD  output  32  head PC
- adelD  output  1  head address-error flag
- countQ  output  ADDR_W+1  occupancy, 0..DEPTH

## Operation
- Storage: DEPTH entries of {pc[31:0], instr[31:0], adel}. Write pointer wr_ptr and read pointer rd_ptr are ADDR_W bits and wrap modulo DEPTH. countQ is ADDR_W+1 bits.
- push = fetch_valid & fetch_ready & ~flushD.
- pop = validD & ~stallD & ~flushD.
- fetch_ready = ~rst & (countQ != DEPTH). It depends only on registered state, never on stallD or fetch_valid.
- validD = (countQ != 0).
- Head outputs are combinational from entry[rd_ptr] when validD=1.
- When validD=0, instrD=32'h0000_0000 (sll $0,$0,0 bubble), pcD=32'h0, adelD=0. Entry contents are never exposed while empty.
- On push: write entry[wr_ptr], then wr_ptr+1. On pop: rd_ptr+1.
- countQ update: push only +1; pop only −1; push and pop together unchanged.
- Priority: rst > flushD > push/pop. On rst or flushD: wr_ptr=rd_ptr=0, countQ=0, entries are not cleared. A push offered in a flush cycle is dropped, and fetch must re-issue from the redirect PC.
- Full: fetch_ready=0, so no push, even if a pop occurs in the same cycle. Fetch sees ready again the next cycle.
- Empty: no pop is possible. A push in the empty cycle makes the entry visible on validD the next cycle; there is no bypass.
- adel entries are queued like normal entries; the queue does not interpret them.

## Timing
- Reset values, in the cycle after rst is sampled high: countQ=0, validD=0, instrD=0, pcD=0, adelD=0, fetch_ready=1. fetch_ready=0 while rst=1.
- Push-to-head latency: 1 cycle (entry pushed at edge N is at the decode outputs after edge N).
- Steady state with stallD=0: 1 instruction/cycle throughput once countQ≥1.
- stallD=1: instrD/pcD/adelD stay stable. Pushes continue until full.
- flushD at edge N: outputs show the bubble after edge N. A new push at edge N+1 is visible after N+1.
- rst mid-operation behaves identically to flushD, plus fetch_ready=0 during the reset cycle.

## Test plan
- Reset then idle: hold rst 2 cycles, then release -> countQ=0, validD=0, instrD=0, fetch_ready=1.
- Streaming: push PCs 0xBFC00000, 0xBFC00004, 0xBFC00008 on consecutive cycles with stallD=0 -> each appears on pcD exactly one cycle after its push; countQ stays 1; instrD matches in order.
- Fill and stall: with stallD=1, push 5 entries offered back-to-back -> 4 accepted, fetch_ready=0 after the 4th, countQ=4, head stays 0xBFC00000. Release stallD -> pops in order, fetch_ready=1 one cycle after the first pop, 5th entry accepted and ordered last.
- Wrap-around: push/pop 10 entries with random stallD -> order preserved across pointer wrap; countQ never exceeds 4 or goes below 0.
- Flush with simultaneous push and pop: countQ=3, flushD=1 with fetch_valid=1 and stallD=0 -> next cycle countQ=0, validD=0, pushed entry absent. Push 0x80000180 the next cycle -> it becomes head.
- adel passthrough: push with fetch_adel=1 at pc 0x00000001 -> adelD=1 only while that entry is head.
